// File: rtl/add2_sum_accumulator.sv
// Accumulates COUNT adder sums (or fewer, on flush) into a frame total on a valid/ready port.
// Optional macro ADD2_ACC_SATURATE_EN: clamp the total at 2^ACC_W-1 instead of wrapping.
module add2_sum_accumulator #(
   parameter  int ACC_W = 8,
   parameter  int COUNT = 4,
   localparam int CNT_W = $clog2(COUNT + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_sum,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [ACC_W-1:0]   out_acc_q, out_acc_d;
   logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
   logic               out_ovf_q, out_ovf_d;

   logic               accept;
   logic               close;
   logic [ACC_W:0]     sum_ext;
   logic               carry;
   logic [ACC_W-1:0]   acc_add;
   logic [CNT_W-1:0]   cnt_inc;

   assign accept  = in_valid && (state_q == ACCUM);
   assign sum_ext = {1'b0, acc_q} + {{(ACC_W-2){1'b0}}, in_sum};
   assign carry   = sum_ext[ACC_W];
   assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef ADD2_ACC_SATURATE_EN
   // Once clamped, any further add either carries again or adds zero, so it stays clamped.
   assign acc_add = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
   assign acc_add = sum_ext[ACC_W-1:0];
`endif

   // Flush with an empty frame and no sum this cycle must not emit a result.
   assign close = (accept && (cnt_inc == CNT_W'(COUNT))) ||
                  (flush && ((cnt_q != '0) || accept));

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      out_acc_d = out_acc_q;
      out_cnt_d = out_cnt_q;
      out_ovf_d = out_ovf_q;
      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               acc_d = acc_add;
               cnt_d = cnt_inc;
               ovf_d = ovf_q | carry;
            end
            if (close) begin
               state_d   = HOLD;
               out_acc_d = acc_d;
               out_cnt_d = cnt_d;
               out_ovf_d = ovf_d;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         out_acc_q <= '0;
         out_cnt_q <= '0;
         out_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         out_acc_q <= out_acc_d;
         out_cnt_q <= out_cnt_d;
         out_ovf_q <= out_ovf_d;
      end
   end

   assign in_ready  = (state_q == ACCUM) && !reset;
   assign out_valid = (state_q == HOLD);
   assign out_acc   = out_acc_q;
   assign out_cnt   = out_cnt_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_add2_sum_accumulator.sv
// Scoreboard bench for add2_sum_accumulator: directed test-plan frames followed by random traffic.
module tb_add2_sum_accumulator;

   localparam int TA    = 4;
   localparam int TC    = 4;
   localparam int TCW   = $clog2(TC + 1);
   localparam int MAXV  = (1 << TA) - 1;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [2:0]     in_sum = 3'd0;
   logic           flush = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [TA-1:0]  out_acc;
   logic [TCW-1:0] out_cnt;
   logic           out_ovf;

   add2_sum_accumulator #(.ACC_W(TA), .COUNT(TC)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_acc(out_acc), .out_cnt(out_cnt), .out_ovf(out_ovf)
   );

   always #5 clock = ~clock;

   typedef struct { int acc; int cnt; bit ovf; } exp_t;
   exp_t q[$];

   int  checks = 0;
   int  errors = 0;
   bit  started = 0;
   bit  m_hold = 0;
   int  m_tot = 0;
   int  m_n = 0;
   bit  rst_seen = 0;

   task automatic chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic exp_t make_exp(int tot, int n);
      exp_t e;
      e.cnt = n;
      e.ovf = (tot > MAXV);
`ifdef ADD2_ACC_SATURATE_EN
      e.acc = (tot > MAXV) ? MAXV : tot;
`else
      e.acc = tot % (MAXV + 1);
`endif
      return e;
   endfunction

   // One cycle of stimulus; the model advances for the edge these inputs will meet.
   task automatic step(bit v, int s, bit f, bit r, bit rst);
      @(negedge clock);
      in_valid  = v;
      in_sum    = 3'(s);
      flush     = f;
      out_ready = r;
      reset     = rst;
      #2;
      if (started) chk("in_ready", int'(in_ready), int'(!m_hold && !rst));
      if (rst_seen) begin
         chk("rst_out_acc", int'(out_acc), 0);
         chk("rst_out_cnt", int'(out_cnt), 0);
         chk("rst_out_ovf", int'(out_ovf), 0);
      end
      if (rst) begin
         m_hold = 0; m_tot = 0; m_n = 0;
         q.delete();
      end else if (m_hold) begin
         if (r) m_hold = 0;
      end else begin
         if (v) begin
            m_tot += s;
            m_n++;
         end
         if ((v && m_n == TC) || (f && m_n > 0)) begin
            q.push_back(make_exp(m_tot, m_n));
            m_hold = 1; m_tot = 0; m_n = 0;
         end
      end
      rst_seen = rst;
      started  = 1;
   endtask

   // Monitor: compares the presented result against the scoreboard head every cycle it is valid.
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (started) begin
            chk("out_valid", int'(out_valid), int'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
               chk("out_acc", int'(out_acc), q[0].acc);
               chk("out_cnt", int'(out_cnt), q[0].cnt);
               chk("out_ovf", int'(out_ovf), int'(q[0].ovf));
               if (out_ready && !reset) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      // basic frame
      step(1, 3, 0, 1, 0); step(1, 6, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 2, 0, 1, 0);
      step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
      // backpressure with ignored input pulses
      step(1, 2, 0, 0, 0); step(1, 2, 0, 0, 0); step(1, 2, 0, 0, 0); step(1, 2, 0, 0, 0);
      step(1, 5, 1, 0, 0); step(1, 6, 0, 0, 0); step(1, 4, 1, 0, 0); step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      // gaps and flush, then empty flush
      step(1, 5, 0, 1, 0); step(0, 0, 0, 1, 0); step(1, 4, 0, 1, 0); step(0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0); step(0, 0, 1, 1, 0); step(0, 0, 1, 1, 0); step(0, 0, 0, 1, 0);
      // flush on the same cycle as a sum
      step(1, 6, 1, 1, 0); step(0, 0, 0, 1, 0);
      // overflow, then a clean frame
      for (int i = 0; i < 4; i++) step(1, 6, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      // reset mid-frame
      step(1, 4, 0, 1, 0); step(1, 5, 0, 1, 0); step(0, 0, 0, 1, 1);
      step(1, 1, 0, 1, 0); step(1, 2, 0, 1, 0); step(1, 3, 0, 1, 0); step(1, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      // reset during HOLD
      for (int i = 0; i < 4; i++) step(1, 6, 0, 0, 0);
      step(0, 0, 0, 0, 0); step(1, 3, 0, 1, 1);
      step(1, 1, 0, 1, 0); step(1, 2, 0, 1, 0); step(1, 3, 0, 1, 0); step(1, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 6), $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
      end
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
